// File: rtl/seq_num_alloc_arb.sv
// seq_num_alloc_arb: round-robin arbiter that shares one sequence-number
// generator among p_num_req fetch requesters. The grant path is combinational.
// Optional macro SEQ_NUM_ARB_CREDIT_EN builds a per-requester in-flight cap.
// The cap is fed by an ownership table that commit notifications update.
module seq_num_alloc_arb #(
  parameter int unsigned p_seq_num_bits = 5,
  parameter int unsigned p_num_req      = 2,
  parameter int unsigned p_max_inflight = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [p_seq_num_bits-1:0]           gen_seq_num,
  input  logic                                gen_val,
  output logic                                gen_rdy,
  output logic [p_num_req*p_seq_num_bits-1:0] req_seq_num,
  output logic [p_num_req-1:0]                req_val,
  input  logic [p_num_req-1:0]                req_rdy,
  input  logic                                commit_val,
  input  logic [p_seq_num_bits-1:0]           commit_seq_num
);

  localparam int unsigned lp_ptr_w = $clog2(p_num_req);

  logic [lp_ptr_w-1:0]  r_ptr;
  logic [lp_ptr_w-1:0]  w_grant;
  logic [lp_ptr_w-1:0]  w_ptr_nxt;
  logic [p_num_req-1:0] w_elig;
  logic                 w_any;
  logic                 w_fire;

`ifdef SEQ_NUM_ARB_CREDIT_EN
  localparam int unsigned lp_tbl   = 2**p_seq_num_bits;
  localparam int unsigned lp_cnt_w = $clog2(p_max_inflight + 1);

  logic [lp_cnt_w-1:0]  r_inflight  [p_num_req];
  logic                 r_owner_val [lp_tbl];
  logic [lp_ptr_w-1:0]  r_owner_id  [lp_tbl];
  logic                 w_commit_hit;
  logic [lp_ptr_w-1:0]  w_commit_owner;
  logic [p_num_req-1:0] w_inc;
  logic [p_num_req-1:0] w_dec;

  assign w_commit_hit   = commit_val && r_owner_val[commit_seq_num];
  assign w_commit_owner = r_owner_id[commit_seq_num];

  // Eligibility: ready and below the in-flight cap (registered counts only)
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < p_num_req; i++) begin
      w_elig[i] = req_rdy[i] && (r_inflight[i] < lp_cnt_w'(p_max_inflight));
    end
  end

  // Per-requester increment/decrement strobes for this cycle
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_fire)       w_inc[w_grant]        = 1'b1;
    if (w_commit_hit) w_dec[w_commit_owner] = 1'b1;
  end

  // In-flight counters; simultaneous grant and commit to one requester cancel out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < p_num_req; i++) r_inflight[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < p_num_req; i++) begin
        if (w_inc[i] && !w_dec[i])      r_inflight[i] <= r_inflight[i] + lp_cnt_w'(1);
        else if (w_dec[i] && !w_inc[i]) r_inflight[i] <= r_inflight[i] - lp_cnt_w'(1);
      end
    end
  end

  // Ownership table: commit clears the old entry first, a same-index allocation then wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < lp_tbl; i++) begin
        r_owner_val[i] <= 1'b0;
        r_owner_id[i]  <= '0;
      end
    end else begin
      if (w_commit_hit) r_owner_val[commit_seq_num] <= 1'b0;
      if (w_fire) begin
        r_owner_val[gen_seq_num] <= 1'b1;
        r_owner_id[gen_seq_num]  <= w_grant;
      end
    end
  end
`else
  localparam int unsigned lp_unused_max_inflight = p_max_inflight;
  logic w_unused_commit;

  assign w_unused_commit = ^{commit_val, commit_seq_num};
  assign w_elig          = req_rdy;
`endif

  // Round-robin scan: first eligible index starting at r_ptr, wrapping
  always_comb begin : grant_scan
    int unsigned v_idx;
    v_idx   = 0;
    w_grant = '0;
    w_any   = 1'b0;
    for (int unsigned j = 0; j < p_num_req; j++) begin
      v_idx = (32'(r_ptr) + j) % p_num_req;
      if (!w_any && w_elig[lp_ptr_w'(v_idx)]) begin
        w_any   = 1'b1;
        w_grant = lp_ptr_w'(v_idx);
      end
    end
  end

  // Outputs are held off while reset is asserted, whatever req_rdy does
  assign gen_rdy     = rst && w_any;
  assign w_fire      = gen_val && gen_rdy;
  assign req_seq_num = {p_num_req{gen_seq_num}};
  assign w_ptr_nxt   = (w_grant == lp_ptr_w'(p_num_req - 1)) ? '0 : w_grant + lp_ptr_w'(1);

  // One-hot grant of the offer
  always_comb begin
    req_val = '0;
    if (w_fire) req_val[w_grant] = 1'b1;
  end

  // Round-robin pointer moves past the winner only on a handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_ptr <= '0;
    else if (w_fire) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: tb/tb_seq_num_alloc_arb.sv
// Directed bench for seq_num_alloc_arb (p_num_req=2, p_max_inflight=2).
// Expected values depend on whether SEQ_NUM_ARB_CREDIT_EN is defined.
module tb_seq_num_alloc_arb;

`ifdef SEQ_NUM_ARB_CREDIT_EN
  localparam bit lp_credit = 1'b1;
`else
  localparam bit lp_credit = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  gen_seq_num;
  logic        gen_val;
  logic        gen_rdy;
  logic [9:0]  req_seq_num;
  logic [1:0]  req_val;
  logic [1:0]  req_rdy;
  logic        commit_val;
  logic [4:0]  commit_seq_num;

  int checks   = 0;
  int failures = 0;

  seq_num_alloc_arb #(
    .p_seq_num_bits (5),
    .p_num_req      (2),
    .p_max_inflight (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .gen_seq_num    (gen_seq_num),
    .gen_val        (gen_val),
    .gen_rdy        (gen_rdy),
    .req_seq_num    (req_seq_num),
    .req_val        (req_val),
    .req_rdy        (req_rdy),
    .commit_val     (commit_val),
    .commit_seq_num (commit_seq_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs for a cycle where the credit cap blocks the offer
  function automatic logic cap_gr();
    return !lp_credit;
  endfunction

  function automatic logic [1:0] cap_rv(input logic [1:0] rv);
    return lp_credit ? 2'b00 : rv;
  endfunction

  // One cycle: drive at posedge+1, check combinational outputs, advance
  task automatic cyc(input string tag, input logic [1:0] rdy, input logic gv,
                     input logic [4:0] sn, input logic cv, input logic [4:0] cs,
                     input logic exp_gr, input logic [1:0] exp_rv);
    req_rdy        = rdy;
    gen_val        = gv;
    gen_seq_num    = sn;
    commit_val     = cv;
    commit_seq_num = cs;
    #2;
    chk({tag, ".gen_rdy"}, 32'(gen_rdy), 32'(exp_gr));
    chk({tag, ".req_val"}, 32'(req_val), 32'(exp_rv));
    chk({tag, ".seq"},     32'(req_seq_num), 32'({sn, sn}));
    @(posedge clk);
    #1;
    commit_val = 1'b0;
  endtask

  task automatic reset_pulse();
    gen_val    = 1'b0;
    commit_val = 1'b0;
    req_rdy    = 2'b11;
    rst        = 1'b0;
    #1;
    chk("rstp.gen_rdy", 32'(gen_rdy), 32'(1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    req_rdy        = 2'b11;
    gen_val        = 1'b1;
    gen_seq_num    = 5'd0;
    commit_val     = 1'b0;
    commit_seq_num = 5'd0;
    #2;
    chk("reset.gen_rdy", 32'(gen_rdy), 32'(1'b0));
    chk("reset.req_val", 32'(req_val), 32'(2'b00));
    gen_val = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;

    // Single requester and credit cap
    cyc("single0", 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01);
    cyc("single1", 2'b01, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 2'b01);
    cyc("single2", 2'b01, 1'b1, 5'd2, 1'b0, 5'd0, cap_gr(), cap_rv(2'b01));
    cyc("cap_cm0", 2'b01, 1'b1, 5'd2, 1'b1, 5'd0, cap_gr(), cap_rv(2'b01));
    cyc("cap_rel", 2'b01, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 2'b01);
    reset_pulse();

    // Round-robin alternation and pointer position after four grants
    cyc("rr0", 2'b11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01);
    cyc("rr1", 2'b11, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 2'b10);
    cyc("rr2", 2'b11, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 2'b01);
    cyc("rr3", 2'b11, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 2'b10);
    cyc("rr_cm0", 2'b11, 1'b0, 5'd0, 1'b1, 5'd0, cap_gr(), 2'b00);
    cyc("rr_cm1", 2'b11, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 2'b00);
    cyc("rr4", 2'b11, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 2'b01);
    cyc("rr5", 2'b11, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 2'b10);
    reset_pulse();

    // Unowned and repeated commits are ignored
    cyc("un_g5",  2'b10, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 2'b10);
    cyc("un_c7",  2'b10, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 2'b00);
    cyc("un_g6",  2'b10, 1'b1, 5'd6, 1'b0, 5'd0, 1'b1, 2'b10);
    cyc("un_b8",  2'b10, 1'b1, 5'd8, 1'b0, 5'd0, cap_gr(), cap_rv(2'b10));
    cyc("un_c5a", 2'b10, 1'b0, 5'd0, 1'b1, 5'd5, cap_gr(), 2'b00);
    cyc("un_c5b", 2'b10, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 2'b00);
    cyc("un_g8",  2'b10, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 2'b10);
    cyc("un_b9",  2'b10, 1'b1, 5'd9, 1'b0, 5'd0, cap_gr(), cap_rv(2'b10));
    cyc("un_r0",  2'b01, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 2'b01);
    reset_pulse();

    // Simultaneous grant and commit, including commit index == offered index
    cyc("si_g3",   2'b10, 1'b1, 5'd3,  1'b0, 5'd0,  1'b1, 2'b10);
    cyc("si_g4c3", 2'b10, 1'b1, 5'd4,  1'b1, 5'd3,  1'b1, 2'b10);
    cyc("si_c3",   2'b10, 1'b0, 5'd0,  1'b1, 5'd3,  1'b1, 2'b00);
    cyc("si_g10",  2'b10, 1'b1, 5'd10, 1'b0, 5'd0,  1'b1, 2'b10);
    cyc("si_b11",  2'b10, 1'b1, 5'd11, 1'b0, 5'd0,  cap_gr(), cap_rv(2'b10));
    cyc("si_c4",   2'b10, 1'b0, 5'd0,  1'b1, 5'd4,  cap_gr(), 2'b00);
    cyc("si_g11",  2'b10, 1'b1, 5'd11, 1'b0, 5'd0,  1'b1, 2'b10);
    cyc("si_same", 2'b01, 1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 2'b01);
    cyc("si_g13",  2'b10, 1'b1, 5'd13, 1'b0, 5'd0,  1'b1, 2'b10);
    cyc("si_b14",  2'b10, 1'b1, 5'd14, 1'b0, 5'd0,  cap_gr(), cap_rv(2'b10));
    cyc("si_c10",  2'b10, 1'b0, 5'd0,  1'b1, 5'd10, cap_gr(), 2'b00);
    cyc("si_g15",  2'b01, 1'b1, 5'd15, 1'b0, 5'd0,  1'b1, 2'b01);
    cyc("si_g16",  2'b01, 1'b1, 5'd16, 1'b0, 5'd0,  1'b1, 2'b01);
    cyc("si_b17",  2'b01, 1'b1, 5'd17, 1'b0, 5'd0,  cap_gr(), cap_rv(2'b01));
    reset_pulse();

    // Asynchronous reset in the middle of operation
    cyc("mr_g0", 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 2'b01);
    cyc("mr_g1", 2'b01, 1'b1, 5'd1, 1'b0, 5'd0, 1'b1, 2'b01);
    req_rdy     = 2'b11;
    gen_val     = 1'b1;
    gen_seq_num = 5'd2;
    #1;
    chk("mr_pre.req_val", 32'(req_val), 32'(2'b10));
    rst = 1'b0;
    #1;
    chk("mr_low.gen_rdy", 32'(gen_rdy), 32'(1'b0));
    chk("mr_low.req_val", 32'(req_val), 32'(2'b00));
    #1;
    rst = 1'b1;
    #1;
    chk("mr_post.req_val", 32'(req_val), 32'(2'b01));
    @(posedge clk);
    #1;
    cyc("mr_g3", 2'b01, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, 2'b01);
    cyc("mr_b4", 2'b01, 1'b1, 5'd4, 1'b0, 5'd0, cap_gr(), cap_rv(2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
